// File: rtl/queue_if.sv
// Handshake bundle between a producer/consumer (master) and the FIFO (slave).
// CNTW must match the occupancy width the FIFO derives from LENGTH.
interface queue_if #(
   parameter int WIDTH  = 8,
   parameter int LENGTH = 5
);
   localparam int CNTW = $clog2(LENGTH + 1);

   logic             push_i;
   logic             pop_i;
   logic [WIDTH-1:0] data_i;
   logic [WIDTH-1:0] data_o;
   logic             full;
   logic             empty;
   logic [CNTW-1:0]  count_o;
   logic             overflow;
   logic             underflow;

   modport master (
      output push_i, pop_i, data_i,
      input  data_o, full, empty, count_o, overflow, underflow
   );

   modport slave (
      input  push_i, pop_i, data_i,
      output data_o, full, empty, count_o, overflow, underflow
   );
endinterface

// File: rtl/queue.sv
// Synchronous FIFO on a circular buffer with read/write pointers and an occupancy
// counter; registered read data and registered overflow/underflow pulses.
module queue #(
   parameter int WIDTH  = 8,
   parameter int LENGTH = 5
) (
   input logic   clk,
   input logic   rstn,
   queue_if.slave q
);
   localparam int CNTW = $clog2(LENGTH + 1);
   localparam int PTRW = $clog2(LENGTH);

   logic [WIDTH-1:0] mem [LENGTH];
   logic [PTRW-1:0]  wr_ptr, rd_ptr;
   logic [CNTW-1:0]  count;
   logic [WIDTH-1:0] data_q;
   logic             overflow_q, underflow_q;
   logic             full_w, empty_w;
   logic             push_ok, pop_ok;

   assign full_w  = (count == CNTW'(LENGTH));
   assign empty_w = (count == '0);

   // A push into a full FIFO is allowed when a pop is requested alongside it;
   // there is no bypass, so a pop into an empty FIFO is always rejected.
   assign pop_ok  = q.pop_i & ~empty_w;
   assign push_ok = q.push_i & (~full_w | q.pop_i);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= q.data_i;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         data_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= q.push_i & ~push_ok;
         underflow_q <= q.pop_i & ~pop_ok;
         if (pop_ok) begin
            data_q <= mem[rd_ptr];
            rd_ptr <= (rd_ptr == PTRW'(LENGTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         if (push_ok)
            wr_ptr <= (wr_ptr == PTRW'(LENGTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (pop_ok && !push_ok)
            count <= count - 1'b1;
      end
   end

   assign q.data_o    = data_q;
   assign q.full      = full_w;
   assign q.empty     = empty_w;
   assign q.count_o   = count;
   assign q.overflow  = overflow_q;
   assign q.underflow = underflow_q;
endmodule

// File: tb/tb_queue.sv
// Directed bench for queue: a reference FIFO (scoreboard queue) predicts every output.
module tb_queue;
   localparam int WIDTH  = 8;
   localparam int LENGTH = 5;

   logic clk;
   logic rstn;

   queue_if #(.WIDTH(WIDTH), .LENGTH(LENGTH)) qif ();

   queue #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .q    (qif.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned passed = 0;
   int unsigned total  = 0;

   logic [7:0] sb [$];
   logic [7:0] exp_data;
   logic       exp_ovf, exp_unf;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".data_o"},    qif.data_o, exp_data);
      chk({tag, ".count_o"},   8'(qif.count_o), 8'(sb.size()));
      chk({tag, ".full"},      8'(qif.full), 8'(sb.size() == LENGTH));
      chk({tag, ".empty"},     8'(qif.empty), 8'(sb.size() == 0));
      chk({tag, ".overflow"},  8'(qif.overflow), 8'(exp_ovf));
      chk({tag, ".underflow"}, 8'(qif.underflow), 8'(exp_unf));
   endtask

   task automatic model_reset();
      sb.delete();
      exp_data = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
   endtask

   // Drive one cycle of stimulus, predict from the pre-edge state, check 1 ns after the edge.
   task automatic step(input string tag, input logic push, input logic pop, input logic [7:0] d);
      logic pop_ok, push_ok;
      qif.push_i = push;
      qif.pop_i  = pop;
      qif.data_i = d;
      pop_ok  = pop && (sb.size() != 0);
      push_ok = push && ((sb.size() < LENGTH) || pop);
      @(posedge clk);
      if (pop_ok)  exp_data = sb.pop_front();
      if (push_ok) sb.push_back(d);
      exp_ovf = push && !push_ok;
      exp_unf = pop && !pop_ok;
      #1;
      check_all(tag);
   endtask

   initial begin
      qif.push_i = 1'b0;
      qif.pop_i  = 1'b0;
      qif.data_i = '0;
      rstn = 1'b0;
      model_reset();
      #20;
      check_all("reset");
      #2 rstn = 1'b1;

      for (int i = 0; i < 16; i++) step("overfill", 1'b1, 1'b0, 8'("a" + i));
      for (int i = 0; i < 20; i++) step("drain", 1'b0, 1'b1, 8'h00);
      chk("drain_holds_e", qif.data_o, 8'("e"));

      for (int i = 0; i < 16; i++) step("simul", 1'b1, 1'b1, 8'("a" + i));
      chk("simul_lag_o", qif.data_o, 8'("o"));
      step("empty_out", 1'b0, 1'b1, 8'h00);

      for (int i = 0; i < 3; i++) step("wrap_push", 1'b1, 1'b0, 8'("a" + i));
      for (int i = 0; i < 3; i++) step("wrap_pop", 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 5; i++) step("wrap_fill", 1'b1, 1'b0, 8'("d" + i));
      step("full_both", 1'b1, 1'b1, 8'("i"));
      chk("full_both_d", qif.data_o, 8'("d"));
      for (int i = 0; i < 6; i++) step("wrap_drain", 1'b0, 1'b1, 8'h00);
      chk("wrap_last_i", qif.data_o, 8'("i"));

      for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 8'("x" + i));
      qif.push_i = 1'b0;
      #2 rstn = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      rstn = 1'b1;
      step("post_rst_pop", 1'b0, 1'b1, 8'h00);
      step("post_rst_idle", 1'b0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not reach end of sequence");
      $fatal(1, "timeout");
   end
endmodule
